// File: rtl/fft8_frame_ctrl_if.sv
// Bundle of the sample stream, core lane buses and bin stream around fft8_frame_ctrl.
// slave = controller view, master = surrounding logic (source, core, sink).
interface fft8_frame_ctrl_if #(
  parameter int unsigned DW = 16
);
  localparam int unsigned VW = 8 * DW;

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_re;
  logic [DW-1:0] s_im;
  logic          core_en;
  logic [VW-1:0] core_xin;
  logic [VW-1:0] core_yin;
  logic [VW-1:0] core_xout;
  logic [VW-1:0] core_yout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_re;
  logic [DW-1:0] m_im;
  logic [2:0]    m_index;
  logic          m_last;
  logic          busy;

  modport slave (
    input  s_valid, s_re, s_im, core_xout, core_yout, m_ready,
    output s_ready, core_en, core_xin, core_yin, m_valid, m_re, m_im, m_index, m_last, busy
  );

  modport master (
    output s_valid, s_re, s_im, core_xout, core_yout, m_ready,
    input  s_ready, core_en, core_xin, core_yin, m_valid, m_re, m_im, m_index, m_last, busy
  );
endinterface

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point CORDIC FFT core: gather 8 samples, run core, stream 8 bins.
// Optional FFT8_BITREV_LOAD_EN: load sample n into slot bitrev3(n) so bins leave in natural order.
module fft8_frame_ctrl #(
  parameter int unsigned DW       = 16,
  parameter int unsigned CORE_LAT = 34
) (
  input  logic             clock,
  input  logic             rst_n,
  fft8_frame_ctrl_if.slave bus
);
  localparam int unsigned VW = 8 * DW;
  localparam int unsigned LW = 8;

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [VW-1:0] xin_q, xin_d, yin_q, yin_d;
  logic [VW-1:0] xout_q, xout_d, yout_q, yout_d;
  logic [DW-1:0] m_re_q, m_re_d, m_im_q, m_im_d;
  logic          s_ready_q, s_ready_d;
  logic          core_en_q, core_en_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          busy_q, busy_d;
  logic [2:0]    slot_c;
  logic          s_fire_c, m_fire_c, cap_c;

`ifdef FFT8_BITREV_LOAD_EN
  assign slot_c = {cnt_q[0], cnt_q[1], cnt_q[2]};
`else
  assign slot_c = cnt_q;
`endif

  // Next state, datapath registers and registered-output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    xin_d    = xin_q;
    yin_d    = yin_q;
    xout_d   = xout_q;
    yout_d   = yout_q;
    cap_c    = 1'b0;
    s_fire_c = bus.s_valid && s_ready_q && (state_q == LOAD);
    m_fire_c = m_valid_q && bus.m_ready;

    unique case (state_q)
      LOAD: begin
        if (s_fire_c) begin
          xin_d[DW*32'(slot_c) +: DW] = bus.s_re;
          yin_d[DW*32'(slot_c) +: DW] = bus.s_im;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = RUN;
            lat_d   = '0;
          end
        end
      end
      RUN: begin
        if (lat_q == LW'(CORE_LAT - 1)) begin
          cap_c   = 1'b1;
          xout_d  = bus.core_xout;
          yout_d  = bus.core_yout;
          lat_d   = '0;
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      DRAIN: begin
        if (m_fire_c) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    s_ready_d = (state_d == LOAD);
    core_en_d = (state_d == RUN);
    m_valid_d = (state_d == DRAIN);
    m_last_d  = m_valid_d && (idx_d == 3'd7);
    busy_d    = (cnt_d != 3'd0) || (state_d != LOAD);
    // On the capture edge the output register is still being loaded, so tap the core directly
    m_re_d    = cap_c ? bus.core_xout[DW*32'(idx_d) +: DW] : xout_q[DW*32'(idx_d) +: DW];
    m_im_d    = cap_c ? bus.core_yout[DW*32'(idx_d) +: DW] : yout_q[DW*32'(idx_d) +: DW];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      idx_q     <= '0;
      lat_q     <= '0;
      xin_q     <= '0;
      yin_q     <= '0;
      xout_q    <= '0;
      yout_q    <= '0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      s_ready_q <= 1'b1;
      core_en_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lat_q     <= lat_d;
      xin_q     <= xin_d;
      yin_q     <= yin_d;
      xout_q    <= xout_d;
      yout_q    <= yout_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      s_ready_q <= s_ready_d;
      core_en_q <= core_en_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.core_en  = core_en_q;
  assign bus.core_xin = xin_q;
  assign bus.core_yin = yin_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_re     = m_re_q;
  assign bus.m_im     = m_im_q;
  assign bus.m_index  = idx_q;
  assign bus.m_last   = m_last_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl around a pass-through stub core.
// Honours FFT8_BITREV_LOAD_EN for the expected bin order.
module tb_fft8_frame_ctrl;
  localparam int unsigned DW       = 16;
  localparam int unsigned CORE_LAT = 4;
  localparam int unsigned VW       = 8 * DW;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ord [8];

  fft8_frame_ctrl_if #(.DW(DW)) bus ();

  fft8_frame_ctrl #(.DW(DW), .CORE_LAT(CORE_LAT)) dut (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub core: identity, result usable at the CORE_LAT-th edge after inputs settle
  logic [VW-1:0] px [CORE_LAT-1];
  logic [VW-1:0] py [CORE_LAT-1];
  always @(posedge clk) begin
    px[0] <= bus.core_xin;
    py[0] <= bus.core_yin;
    for (int i = 1; i < int'(CORE_LAT) - 1; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign bus.core_xout = px[CORE_LAT-2];
  assign bus.core_yout = py[CORE_LAT-2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd1);
    check({tag, "_core_en"}, 64'(bus.core_en), 64'd0);
    check({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
    check({tag, "_m_last"},  64'(bus.m_last),  64'd0);
    check({tag, "_m_index"}, 64'(bus.m_index), 64'd0);
    check({tag, "_busy"},    64'(bus.busy),    64'd0);
  endtask

  // Feed nframes*8 samples (s_valid held high until all are consumed) and drain all bins.
  // Sample g carries re = first+g+1, im = -(first+g+1).
  task automatic run(input string tag, input int nframes, input int first, input bit bp);
    int total = 8 * nframes;
    int sent = 0, beats = 0, cyc = 0, dcnt = 0, viol = 0, en_cnt = 0;
    int acc7 = -1, first_mv = -1;
    bit stall = 1'b0;
    logic [DW-1:0] hre = '0, him = '0;
    logic [2:0] hidx = '0;
    logic hlast = 1'b0;
    while (beats < total && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.s_ready && (bus.core_en || bus.m_valid)) viol++;
      if (bus.core_en && beats < 8) en_cnt++;
      if (bus.m_valid && first_mv < 0) first_mv = cyc;
      if (stall) begin
        check({tag, "_hold_valid"}, 64'(bus.m_valid), 64'd1);
        check({tag, "_hold_re"},    64'(bus.m_re),    64'(hre));
        check({tag, "_hold_im"},    64'(bus.m_im),    64'(him));
        check({tag, "_hold_idx"},   64'(bus.m_index), 64'(hidx));
        check({tag, "_hold_last"},  64'(bus.m_last),  64'(hlast));
      end
      stall = 1'b0;
      if (bus.m_valid) begin
        bus.m_ready = bp ? (dcnt % 3 == 0) : 1'b1;
        dcnt++;
        if (bus.m_ready) begin
          int k = beats % 8;
          int v = first + 8 * (beats / 8) + ord[k] + 1;
          logic [DW-1:0] er = DW'(v);
          logic [DW-1:0] ei = DW'(-v);
          check({tag, "_re"},    64'(bus.m_re),    64'(er));
          check({tag, "_im"},    64'(bus.m_im),    64'(ei));
          check({tag, "_index"}, 64'(bus.m_index), 64'(k));
          check({tag, "_last"},  64'(bus.m_last),  64'(k == 7));
          beats++;
        end else begin
          stall = 1'b1;
          hre = bus.m_re; him = bus.m_im; hidx = bus.m_index; hlast = bus.m_last;
        end
      end else begin
        bus.m_ready = !bp;
      end
      if (sent < total) begin
        bus.s_valid = 1'b1;
        bus.s_re    = DW'(first + sent + 1);
        bus.s_im    = DW'(-(first + sent + 1));
        if (bus.s_ready) begin
          if (sent == 7) acc7 = cyc;
          sent++;
        end
      end else begin
        bus.s_valid = 1'b0;
      end
    end
    check({tag, "_beats"}, 64'(beats), 64'(total));
    check({tag, "_sent"},  64'(sent),  64'(total));
    // m_valid first seen in the (CORE_LAT+1)-th cycle after the cycle holding the sample-7 handshake
    check({tag, "_latency"}, 64'(first_mv - acc7), 64'(CORE_LAT + 1));
    check({tag, "_en_cycles"}, 64'(en_cnt), 64'(CORE_LAT));
    check({tag, "_ready_closed"}, 64'(viol), 64'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    check_idle({tag, "_after"});
  endtask

  initial begin
`ifdef FFT8_BITREV_LOAD_EN
    ord = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    ord = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_re = '0;
    bus.s_im = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_xin", 64'(bus.core_xin == '0), 64'd1);
    check("rst_m_re", 64'(bus.m_re), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_rel");

    run("basic", 1, 0, 1'b0);
    run("bp", 1, 16, 1'b1);
    run("cont", 2, 32, 1'b0);

    // Abort mid-RUN with the latency counter at 2
    for (int n = 0; n < 8; n++) begin
      check("abort_ready", 64'(bus.s_ready), 64'd1);
      bus.s_valid = 1'b1;
      bus.s_re = DW'(100 + n);
      bus.s_im = DW'(200 + n);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pre_en", 64'(bus.core_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    check("abort_xin", 64'(bus.core_xin == '0), 64'd1);
    check("abort_m_re", 64'(bus.m_re), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_abort", 1, 64, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft8_frame_ctrl.md
Name: fft8_frame_ctrl

Overview:
- Sequencing controller for the 8-point CORDIC FFT core.
- Accepts a serial stream of complex samples (valid/ready) and assembles 8-sample frames into the core's parallel input bus.
- Holds the core inputs stable and enabled for the core's fixed pipeline latency, captures the 8 parallel results, then streams them out serially with valid/ready and a frame-last flag.

Parameters:
- DW, 16, sample component width; matches core lane width.
- CORE_LAT, 34, clock cycles from stable core input to valid core output (CORDIC pipeline depth); legal range 1..255.

Ports:
- clock  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  controller can accept a sample.
- s_re  input  DW  input sample real part, signed.
- s_im  input  DW  input sample imaginary part, signed.
- core_en  output  1  drives core en.
- core_xin  output  8*DW  real lanes; slot k in bits [DW*k+DW-1 : DW*k]. Integration maps slot 0 to xin1 … slot 7 to xin8.
- core_yin  output  8*DW  imaginary lanes, same packing.
- core_xout  input  8*DW  core real outputs; bin k in bits [DW*k+DW-1 : DW*k].
- core_yout  input  8*DW  core imaginary outputs, same packing.
- m_valid  output  1  output bin valid.
- m_ready  input  1  downstream accepts bin.
- m_re  output  DW  output bin real.
- m_im  output  DW  output bin imaginary.
- m_index  output  3  bin number 0..7 of the current beat.
- m_last  output  1  high with bin 7.
- busy  output  1  high in any state other than LOAD with zero samples held.

Behaviour:
- States: LOAD, RUN, DRAIN. Reset state is LOAD.
- Reset values:
  - s_ready=1, core_en=0, core_xin/core_yin=0, m_valid=0, m_re/m_im=0, m_index=0, m_last=0, busy=0.
  - Sample counter and latency counter are 0.
- LOAD:
  - s_ready=1.
  - On each s_valid&&s_ready edge, the sample n (n = counter 0..7) is written to slot n of the input register, and the counter increments.
  - On acceptance of sample 7: counter returns to 0, state goes to RUN, and s_ready drops in the following cycle.
- RUN:
  - core_en=1, s_ready=0, and the input register is held constant.
  - The latency counter starts at 0 and increments every cycle.
  - When the latency counter equals CORE_LAT-1, at that edge core_xout/core_yout are latched into the output register and the state goes to DRAIN.
  - Capture therefore occurs exactly CORE_LAT edges after the edge that accepted sample 7.
  - core_en returns to 0 after the capture edge.
- DRAIN:
  - m_valid=1, and m_re/m_im present output register bin m_index.
  - On m_valid&&m_ready the index increments.
  - While m_ready=0, all m_* outputs hold stable.
  - On acceptance of bin 7 (m_last=1): m_valid drops, the index resets to 0, the state goes to LOAD, and s_ready=1 from the next cycle.
  - There is no overlap: the controller is single-buffered and sample input is closed during RUN and DRAIN.
- s_valid asserted outside LOAD is ignored; no data is consumed.
- The input register is not cleared between frames; the next frame overwrites all 8 slots.
- busy is high when the sample counter is non-zero or the state is not LOAD.
- Async reset at any point aborts the frame: all state and outputs return to reset values immediately, and partial or in-flight data is discarded.
- No arithmetic is done in the controller; data passes bit-exact.

Optional Feature:
- Macro: FFT8_BITREV_LOAD_EN.
- Defined: sample n is written to slot bitrev3(n), i.e. n=0..7 maps to slots 0,4,2,6,1,5,3,7. Because the core's first butterfly stage pairs adjacent slots, output bins are then in natural DFT order.
- Undefined: sample n is written to slot n. The caller is responsible for pre-ordering the samples.
- Either way, m_index reports the output slot number.

Test Plan:
- Stub core (outputs = inputs after CORE_LAT=4), feed samples re=n+1, im=-(n+1), m_ready=1; macro off -> bins re 1..8 in order, m_last on index 7; first m_valid exactly 5 cycles after sample-7 acceptance edge.
- Same stub with FFT8_BITREV_LOAD_EN -> emitted re sequence 1,5,3,7,2,6,4,8.
- Backpressure: m_ready toggles 1,0,0,1,… during DRAIN -> each bin is held stable while m_ready=0; exactly 8 beats; s_ready stays 0 until bin 7 is accepted, then 1 next cycle.
- s_valid held high continuously across two frames -> exactly 16 samples consumed, none during RUN/DRAIN, second frame data is intact.
- Reset asserted mid-RUN (latency counter = 2) -> all outputs at reset values in the same cycle; after release, a new 8-sample frame completes normally.
- Real core, macro on, all 8 samples re=0x0100, im=0 -> bin 0 is the core's DC value (nonzero); bins 1..7 are within ±4 LSB of 0.
